// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO master.
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    TA,
    DATA,
    DONE
  } mdio_state_e;

  localparam int         MDIO_PRE_BITS = 32;
  localparam logic [1:0] MDIO_ST       = 2'b01;
  localparam logic [1:0] MDIO_OP_WR    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD    = 2'b10;

  // 'reg' is a keyword, so the register address field is named regad.
  typedef struct packed {
    logic        we;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
  } mdio_req_t;

  // ST, OP, PHYAD, REGAD as one 14-bit word, sent MSB first.
  function automatic logic [13:0] mdio_hdr(input mdio_req_t r);
    return {MDIO_ST, (r.we ? MDIO_OP_WR : MDIO_OP_RD), r.phy, r.regad};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: toggles MDC every CLK_DIV cycles while enabled and
// flags the cycle before each edge so the frame logic can act on it.
module mdio_clk_gen #(
  parameter int CLK_DIV = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic mdc_o,
  output logic fall_stb_o,
  output logic rise_stb_o
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q;
  logic          mdc_q;
  logic          half_end;

  assign half_end   = en_i && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_stb_o = half_end && !mdc_q;
  assign fall_stb_o = half_end && mdc_q;
  assign mdc_o      = mdc_q;

  // Half-period counter and MDC toggle; cleared and held low when disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (half_end) begin
      cnt_q <= '0;
      mdc_q <= ~mdc_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master_ctrl.sv
// Clause-22 MDIO master: one read or write frame per accepted request.
// Optional build macro MDIO_PREAMBLE_SUPPRESS_EN skips the 32-bit preamble.
module mdio_master_ctrl
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [4:0]  req_phy_i,
  input  logic [4:0]  req_reg_i,
  input  logic [15:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [15:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);

  mdio_state_e state_q, state_d;
  logic [5:0]  bcnt_q, bcnt_d;
  logic [5:0]  last;
  mdio_req_t   req_q;
  logic [13:0] hdr;
  logic [15:0] shift_q;
  logic [15:0] rdata_q;
  logic        ta_q;
  logic        err_q;
  logic        accept;
  logic        clk_en;
  logic        fall_stb;
  logic        rise_stb;
  logic        frame_end;

  assign accept      = req_valid_i && (state_q == IDLE);
  assign clk_en      = (state_q == PRE) || (state_q == HDR) ||
                       (state_q == TA)  || (state_q == DATA);
  assign frame_end   = (state_q == DATA) && fall_stb && (bcnt_q == 6'd15);
  assign hdr         = mdio_hdr(req_q);

  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (clk_en),
    .mdc_o      (mdc_o),
    .fall_stb_o (fall_stb),
    .rise_stb_o (rise_stb)
  );

  // State and bit counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next state: every field advances on the MDC falling edge once its
  // bit count is exhausted, so each field boundary is also a bit boundary.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      PRE:     last = 6'(MDIO_PRE_BITS - 1);
      HDR:     last = 6'd13;
      TA:      last = 6'd1;
      DATA:    last = 6'd15;
      default: last = 6'd0;
    endcase
    case (state_q)
      IDLE: begin
        if (accept) begin
          bcnt_d  = '0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
          state_d = HDR;
`else
          state_d = PRE;
`endif
        end
      end
      PRE, HDR, TA, DATA: begin
        if (fall_stb) begin
          if (bcnt_q == last) begin
            bcnt_d = '0;
            case (state_q)
              PRE:     state_d = HDR;
              HDR:     state_d = TA;
              TA:      state_d = DATA;
              default: state_d = DONE;
            endcase
          end else begin
            bcnt_d = bcnt_q + 6'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin drive decoded from the registered state; reads release the line
  // for TA and DATA, and an idle or released line reads back as 1.
  always_comb begin
    mdio_o    = 1'b1;
    mdio_oe_o = 1'b0;
    case (state_q)
      PRE: begin
        mdio_oe_o = 1'b1;
      end
      HDR: begin
        mdio_oe_o = 1'b1;
        mdio_o    = hdr[4'd13 - bcnt_q[3:0]];
      end
      TA: begin
        if (req_q.we) begin
          mdio_oe_o = 1'b1;
          mdio_o    = (bcnt_q == 6'd0);
        end
      end
      DATA: begin
        if (req_q.we) begin
          mdio_oe_o = 1'b1;
          mdio_o    = req_q.wdata[4'd15 - bcnt_q[3:0]];
        end
      end
      default: ;
    endcase
  end

  // Request latch, MDIO sampling on MDC rise, and response update at frame end.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q   <= '0;
      shift_q <= '0;
      ta_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        req_q.we    <= req_we_i;
        req_q.phy   <= req_phy_i;
        req_q.regad <= req_reg_i;
        req_q.wdata <= req_wdata_i;
      end
      if (rise_stb && (state_q == TA) && (bcnt_q == 6'd1)) begin
        ta_q <= mdio_i;
      end
      if (rise_stb && (state_q == DATA)) begin
        shift_q <= {shift_q[14:0], mdio_i};
      end
      if (frame_end) begin
        if (req_q.we) begin
          err_q <= 1'b0;
        end else begin
          err_q   <= ta_q;
          rdata_q <= ta_q ? 16'hFFFF : shift_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Directed bench for mdio_master_ctrl with a simple PHY model on mdio_i.
module tb_mdio_master_ctrl;

  localparam int D = 2;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam int P = 0;
`else
  localparam int P = 32;
`endif
  localparam int FB        = P + 32;
  localparam int DONE_CYC  = 1 + FB * 2 * D;
  localparam int ABORT_BIT = (P == 32) ? 40 : 20;
  localparam logic [63:0] MASK = (FB == 64) ? {64{1'b1}} : {32'h0, {32{1'b1}}};

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [4:0]  req_phy_i = '0;
  logic [4:0]  req_reg_i = '0;
  logic [15:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic [15:0] resp_rdata_o;
  logic        resp_err_o;
  logic        busy_o;
  logic        mdc_o;
  logic        mdio_o;
  logic        mdio_oe_o;
  logic        mdio_i = 1'b1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  mdio_master_ctrl #(.CLK_DIV(D)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_phy_i    (req_phy_i),
    .req_reg_i    (req_reg_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .busy_o       (busy_o),
    .mdc_o        (mdc_o),
    .mdio_o       (mdio_o),
    .mdio_oe_o    (mdio_oe_o),
    .mdio_i       (mdio_i)
  );

  always #5 clk_i = ~clk_i;

  // Present a request for one accept edge; returns #1 into cycle 1.
  task automatic issue(input logic we, input logic [4:0] phy, input logic [4:0] rg,
                       input logic [15:0] wd, input logic hold);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_phy_i   = phy;
    req_reg_i   = rg;
    req_wdata_i = wd;
    @(posedge clk_i); #1;
    if (!hold) req_valid_i = 1'b0;
  endtask

  // Step from cycle 1 to resp_valid_o, recording bits at each MDC rise.
  task automatic collect(input logic phy_on, input logic [15:0] pd, output int done,
                         output logic [63:0] bits, output logic [63:0] oe,
                         output int nrise, output int first_rise);
    logic prev_mdc;
    int   b;
    done = -1; bits = '0; oe = '0; nrise = 0; first_rise = -1; prev_mdc = 1'b0;
    for (int n = 1; n <= DONE_CYC + 50; n++) begin
      b = (n - 1) / (2 * D);
      mdio_i = 1'b1;
      if (phy_on) begin
        if (b == P + 15) mdio_i = 1'b0;
        else if (b >= P + 16 && b < P + 32) mdio_i = pd[15 - (b - P - 16)];
      end
      if (mdc_o && !prev_mdc) begin
        bits = {bits[62:0], mdio_o};
        oe   = {oe[62:0], mdio_oe_o};
        nrise++;
        if (first_rise < 0) first_rise = n;
      end
      prev_mdc = mdc_o;
      if (resp_valid_o) begin
        done = n;
        break;
      end
      @(posedge clk_i); #1;
    end
    mdio_i = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk_i); #1;
    tot_cnt++; if (mdc_o !== 1'b0) $display("FAIL rst_mdc got %b exp 0", mdc_o); else pass_cnt++;
    tot_cnt++; if (mdio_o !== 1'b1) $display("FAIL rst_mdio got %b exp 1", mdio_o); else pass_cnt++;
    tot_cnt++; if (mdio_oe_o !== 1'b0) $display("FAIL rst_oe got %b exp 0", mdio_oe_o); else pass_cnt++;
    tot_cnt++; if (req_ready_o !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready_o); else pass_cnt++;
    tot_cnt++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy_o); else pass_cnt++;
    tot_cnt++; if (resp_valid_o !== 1'b0) $display("FAIL rst_rvalid got %b exp 0", resp_valid_o); else pass_cnt++;
    tot_cnt++; if (resp_rdata_o !== 16'h0) $display("FAIL rst_rdata got %h exp 0000", resp_rdata_o); else pass_cnt++;
    tot_cnt++; if (resp_err_o !== 1'b0) $display("FAIL rst_err got %b exp 0", resp_err_o); else pass_cnt++;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_write();
    int done, nrise, fr;
    logic [63:0] bits, oe;
    issue(1'b1, 5'h01, 5'h04, 16'hA5C3, 1'b0);
    collect(1'b0, 16'h0, done, bits, oe, nrise, fr);
    tot_cnt++; if (done != DONE_CYC) $display("FAIL wr_done_cycle got %0d exp %0d", done, DONE_CYC); else pass_cnt++;
    tot_cnt++; if (nrise != FB) $display("FAIL wr_mdc_rises got %0d exp %0d", nrise, FB); else pass_cnt++;
    tot_cnt++; if (fr != 1 + D) $display("FAIL wr_first_rise got %0d exp %0d", fr, 1 + D); else pass_cnt++;
    tot_cnt++; if (bits !== (64'hFFFFFFFF5092A5C3 & MASK)) $display("FAIL wr_bits got %h exp %h", bits, 64'hFFFFFFFF5092A5C3 & MASK); else pass_cnt++;
    tot_cnt++; if (oe !== MASK) $display("FAIL wr_oe got %h exp %h", oe, MASK); else pass_cnt++;
    tot_cnt++; if (resp_err_o !== 1'b0) $display("FAIL wr_err got %b exp 0", resp_err_o); else pass_cnt++;
    tot_cnt++; if ({mdc_o, mdio_o, mdio_oe_o} !== 3'b010) $display("FAIL wr_done_pins got %b exp 010", {mdc_o, mdio_o, mdio_oe_o}); else pass_cnt++;
    @(posedge clk_i); #1;
    tot_cnt++; if ({req_ready_o, busy_o, resp_valid_o} !== 3'b100) $display("FAIL wr_after_done got %b exp 100", {req_ready_o, busy_o, resp_valid_o}); else pass_cnt++;
  endtask

  task automatic test_read();
    int done, nrise, fr;
    logic [63:0] bits, oe, eoe;
    eoe = '0;
    for (int b = 0; b < FB; b++) eoe[FB - 1 - b] = (b < P + 14);
    issue(1'b0, 5'h01, 5'h02, 16'h0, 1'b0);
    collect(1'b1, 16'h1234, done, bits, oe, nrise, fr);
    tot_cnt++; if (done != DONE_CYC) $display("FAIL rd_done_cycle got %0d exp %0d", done, DONE_CYC); else pass_cnt++;
    tot_cnt++; if (resp_rdata_o !== 16'h1234) $display("FAIL rd_data got %h exp 1234", resp_rdata_o); else pass_cnt++;
    tot_cnt++; if (resp_err_o !== 1'b0) $display("FAIL rd_err got %b exp 0", resp_err_o); else pass_cnt++;
    tot_cnt++; if (bits !== (64'hFFFFFFFF608BFFFF & MASK)) $display("FAIL rd_bits got %h exp %h", bits, 64'hFFFFFFFF608BFFFF & MASK); else pass_cnt++;
    tot_cnt++; if (oe !== eoe) $display("FAIL rd_oe got %h exp %h", oe, eoe); else pass_cnt++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_no_phy();
    int done, nrise, fr;
    logic [63:0] bits, oe;
    issue(1'b0, 5'h1F, 5'h00, 16'h0, 1'b0);
    collect(1'b0, 16'h0, done, bits, oe, nrise, fr);
    tot_cnt++; if (done != DONE_CYC) $display("FAIL nophy_done_cycle got %0d exp %0d", done, DONE_CYC); else pass_cnt++;
    tot_cnt++; if (resp_err_o !== 1'b1) $display("FAIL nophy_err got %b exp 1", resp_err_o); else pass_cnt++;
    tot_cnt++; if (resp_rdata_o !== 16'hFFFF) $display("FAIL nophy_data got %h exp FFFF", resp_rdata_o); else pass_cnt++;
    tot_cnt++; if (bits !== (64'hFFFFFFFF6F83FFFF & MASK)) $display("FAIL nophy_bits got %h exp %h", bits, 64'hFFFFFFFF6F83FFFF & MASK); else pass_cnt++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    int done, nrise, fr;
    logic [63:0] bits, oe;
    issue(1'b1, 5'h01, 5'h04, 16'hA5C3, 1'b1);
    collect(1'b0, 16'h0, done, bits, oe, nrise, fr);
    tot_cnt++; if (done != DONE_CYC) $display("FAIL b2b_first_done got %0d exp %0d", done, DONE_CYC); else pass_cnt++;
    tot_cnt++; if (bits !== (64'hFFFFFFFF5092A5C3 & MASK)) $display("FAIL b2b_first_bits got %h exp %h", bits, 64'hFFFFFFFF5092A5C3 & MASK); else pass_cnt++;
    req_phy_i   = 5'h0A;
    req_reg_i   = 5'h1F;
    req_wdata_i = 16'h0F0F;
    @(posedge clk_i); #1;
    tot_cnt++; if (req_ready_o !== 1'b1) $display("FAIL b2b_ready got %b exp 1", req_ready_o); else pass_cnt++;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    tot_cnt++; if ({busy_o, mdio_oe_o, mdio_o, mdc_o} !== 4'b1110) $display("FAIL b2b_second_start got %b exp 1110", {busy_o, mdio_oe_o, mdio_o, mdc_o}); else pass_cnt++;
    collect(1'b0, 16'h0, done, bits, oe, nrise, fr);
    tot_cnt++; if (done != DONE_CYC) $display("FAIL b2b_second_done got %0d exp %0d", done, DONE_CYC); else pass_cnt++;
    tot_cnt++; if (bits !== (64'hFFFFFFFF557E0F0F & MASK)) $display("FAIL b2b_second_bits got %h exp %h", bits, 64'hFFFFFFFF557E0F0F & MASK); else pass_cnt++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_midframe();
    int done, nrise, fr, stray;
    logic [63:0] bits, oe;
    issue(1'b1, 5'h01, 5'h04, 16'hA5C3, 1'b0);
    for (int i = 0; i < ABORT_BIT * 2 * D + D; i++) begin
      @(posedge clk_i); #1;
    end
    tot_cnt++; if ({busy_o, mdc_o} !== 2'b11) $display("FAIL abort_pre_state got %b exp 11", {busy_o, mdc_o}); else pass_cnt++;
    rst_i = 1'b1;
    #1;
    tot_cnt++; if ({mdc_o, mdio_o, mdio_oe_o} !== 3'b010) $display("FAIL abort_pins got %b exp 010", {mdc_o, mdio_o, mdio_oe_o}); else pass_cnt++;
    tot_cnt++; if ({req_ready_o, busy_o, resp_valid_o} !== 3'b100) $display("FAIL abort_ctrl got %b exp 100", {req_ready_o, busy_o, resp_valid_o}); else pass_cnt++;
    tot_cnt++; if ({resp_err_o, resp_rdata_o} !== 17'h0) $display("FAIL abort_resp got %h exp 00000", {resp_err_o, resp_rdata_o}); else pass_cnt++;
    @(negedge clk_i);
    rst_i = 1'b0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (resp_valid_o) stray++;
    end
    tot_cnt++; if (stray != 0) $display("FAIL abort_no_resp got %0d exp 0", stray); else pass_cnt++;
    issue(1'b1, 5'h03, 5'h05, 16'h0001, 1'b0);
    collect(1'b0, 16'h0, done, bits, oe, nrise, fr);
    tot_cnt++; if (done != DONE_CYC) $display("FAIL abort_next_done got %0d exp %0d", done, DONE_CYC); else pass_cnt++;
    tot_cnt++; if (bits !== (64'hFFFFFFFF51960001 & MASK)) $display("FAIL abort_next_bits got %h exp %h", bits, 64'hFFFFFFFF51960001 & MASK); else pass_cnt++;
    @(posedge clk_i); #1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_no_phy();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
